// File: rtl/signal_controller.sv
// Highway / country-road crossing controller: five-state Moore FSM with one dwell counter.
// Optional SIGNAL_CONTROLLER_MIN_GREEN_EN enforces a minimum highway-green dwell of MIN_HWY_GREEN cycles.
module signal_controller #(
  parameter int unsigned Y2RDELAY      = 3,
  parameter int unsigned R2GDELAY      = 2,
  parameter int unsigned MIN_HWY_GREEN = 4
) (
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  input  logic       x,
  input  logic       clear,
  input  logic       clk
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [7:0] Y2R_LAST = 8'(Y2RDELAY - 1);
  localparam logic [7:0] R2G_LAST = 8'(R2GDELAY - 1);
`ifdef SIGNAL_CONTROLLER_MIN_GREEN_EN
  localparam logic [7:0] HWY_LAST = 8'(MIN_HWY_GREEN - 1);
`endif

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] count_r;

  function automatic logic [1:0] hwy_lamp(input state_t s);
    case (s)
      S0:      hwy_lamp = GREEN;
      S1:      hwy_lamp = YELLOW;
      default: hwy_lamp = RED;
    endcase
  endfunction

  function automatic logic [1:0] cntry_lamp(input state_t s);
    case (s)
      S3:      cntry_lamp = GREEN;
      S4:      cntry_lamp = YELLOW;
      default: cntry_lamp = RED;
    endcase
  endfunction

  // Next-state logic; encodings outside S0..S4 fall back to S0.
  always_comb begin
    next_state_s = S0;
    case (state_r)
      S0: begin
`ifdef SIGNAL_CONTROLLER_MIN_GREEN_EN
        if (x && (count_r >= HWY_LAST)) next_state_s = S1;
        else                            next_state_s = S0;
`else
        if (x) next_state_s = S1;
        else   next_state_s = S0;
`endif
      end
      S1: begin
        if (count_r == Y2R_LAST) next_state_s = S2;
        else                     next_state_s = S1;
      end
      S2: begin
        if (count_r == R2G_LAST) next_state_s = S3;
        else                     next_state_s = S2;
      end
      S3: begin
        if (x) next_state_s = S3;
        else   next_state_s = S4;
      end
      S4: begin
        if (count_r == Y2R_LAST) next_state_s = S0;
        else                     next_state_s = S4;
      end
      default: next_state_s = S0;
    endcase
  end

  // State, saturating dwell counter and lamps registered from the next state.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r <= S0;
      count_r <= 8'd0;
      hwy     <= GREEN;
      cntry   <= RED;
    end else begin
      state_r <= next_state_s;
      hwy     <= hwy_lamp(next_state_s);
      cntry   <= cntry_lamp(next_state_s);
      if (next_state_s != state_r) begin
        count_r <= 8'd0;
      end else if (count_r != 8'hFF) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_signal_controller.sv
// Scoreboard bench for signal_controller (default build): stimulus pushes hand-computed lamp
// pairs into a queue, a monitor pops and compares them one cycle later.
module tb_signal_controller;

  logic       clk;
  logic       clear;
  logic       x;
  logic [1:0] hwy;
  logic [1:0] cntry;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [1:0] h;
    logic [1:0] c;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  signal_controller dut (
    .hwy  (hwy),
    .cntry(cntry),
    .x    (x),
    .clear(clear),
    .clk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic c, input logic xv, input logic [1:0] eh,
                      input logic [1:0] ec, input string nm);
    exp_t e;
    @(negedge clk);
    clear = c;
    x     = xv;
    e.h = eh;
    e.c = ec;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic c, input logic xv, input logic [1:0] eh,
                     input logic [1:0] ec, input string nm);
    for (int i = 0; i < n; i++) step(c, xv, eh, ec, nm);
  endtask

  // Monitor: compare lamps just after each rising edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (hwy !== e.h || cntry !== e.c) begin
          n_mismatched++;
          $display("FAIL %s: got hwy=%0d cntry=%0d, expected hwy=%0d cntry=%0d at %0t",
                   e.name, hwy, cntry, e.h, e.c, $time);
        end
      end
    end
  end

  initial begin
    clear = 1'b0;
    x     = 1'b0;

    // Reset held for 5 edges, x ignored while in reset
    run(4, 1'b0, 1'b0, 2'd2, 2'd0, "reset_hold");
    step(1'b0, 1'b1, 2'd2, 2'd0, "reset_ignores_x");
    run(3, 1'b1, 1'b0, 2'd2, 2'd0, "idle_s0");

    // x held high: S1 x3, S2 x2, then S3 while x=1
    run(3, 1'b1, 1'b1, 2'd1, 2'd0, "s1_yellow");
    run(2, 1'b1, 1'b1, 2'd0, 2'd0, "s2_allred");
    run(4, 1'b1, 1'b1, 2'd0, 2'd2, "s3_hold");

    // Drop x in S3: S4 x3 then highway green
    run(3, 1'b1, 1'b0, 2'd0, 2'd1, "s4_yellow");
    run(3, 1'b1, 1'b0, 2'd2, 2'd0, "back_s0");

    // Single-cycle pulse: S1(3) S2(2) S3(1) S4(3) then S0
    step(1'b1, 1'b1, 2'd1, 2'd0, "pulse_s1");
    run(2, 1'b1, 1'b0, 2'd1, 2'd0, "pulse_s1");
    run(2, 1'b1, 1'b0, 2'd0, 2'd0, "pulse_s2");
    step(1'b1, 1'b0, 2'd0, 2'd2, "pulse_s3_min");
    run(3, 1'b1, 1'b0, 2'd0, 2'd1, "pulse_s4");
    run(2, 1'b1, 1'b0, 2'd2, 2'd0, "pulse_s0");

    // Reset during S2 aborts the sequence
    run(3, 1'b1, 1'b1, 2'd1, 2'd0, "pre_abort_s1");
    step(1'b1, 1'b0, 2'd0, 2'd0, "pre_abort_s2");
    step(1'b0, 1'b0, 2'd0 + 2'd2, 2'd0, "abort_s2");
    run(4, 1'b1, 1'b0, 2'd2, 2'd0, "after_abort");

    // Reset during S3 with x still high
    run(3, 1'b1, 1'b1, 2'd1, 2'd0, "s1_again");
    run(2, 1'b1, 1'b1, 2'd0, 2'd0, "s2_again");
    step(1'b1, 1'b1, 2'd0, 2'd2, "s3_again");
    step(1'b0, 1'b1, 2'd2, 2'd0, "abort_s3");

    // Counter restarted by reset mid-S1: a fresh full S1 dwell follows
    step(1'b1, 1'b1, 2'd1, 2'd0, "s1_mid");
    step(1'b0, 1'b0, 2'd2, 2'd0, "abort_s1");
    run(3, 1'b1, 1'b1, 2'd1, 2'd0, "s1_fresh");
    run(2, 1'b1, 1'b0, 2'd0, 2'd0, "s2_fresh");
    step(1'b1, 1'b0, 2'd0, 2'd2, "s3_fresh");
    run(3, 1'b1, 1'b0, 2'd0, 2'd1, "s4_fresh");
    step(1'b1, 1'b0, 2'd2, 2'd0, "s0_fresh");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/signal_controller.md
SIGNAL_CONTROLLER -- requirements
Module: signal_controller

Interface
REQ-001 Parameter Y2RDELAY, default 3: yellow-to-red dwell in clock cycles, legal range 1..255.
REQ-002 Parameter R2GDELAY, default 2: all-red dwell before country green in clock cycles, legal range 1..255.
REQ-003 Parameter MIN_HWY_GREEN, default 4: minimum highway-green dwell in cycles, legal range 1..255; used only when the configuration macro is defined.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 clear  input  1  reset; synchronous, active-low (0 = reset), sampled on rising clk.
REQ-006 hwy  output  2  highway lamp: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN; 2'd3 never driven.
REQ-007 cntry  output  2  country-road lamp, same encoding as hwy.
REQ-008 x  input  1  country-road car sensor, active-high, synchronous to clk.
REQ-009 Port order: hwy, cntry, x, clear, clk.

Function
REQ-010 Moore FSM, five states; outputs decode from state register only, no combinational path x->outputs.
REQ-011 S0: hwy GREEN, cntry RED. S1: hwy YELLOW, cntry RED. S2: hwy RED, cntry RED. S3: hwy RED, cntry GREEN. S4: hwy RED, cntry YELLOW.
REQ-012 S0 -> S1 on the edge where x=1; else remain S0.
REQ-013 S1 lasts exactly Y2RDELAY cycles, then S2; x ignored.
REQ-014 S2 lasts exactly R2GDELAY cycles, then S3; x ignored.
REQ-015 S3: remain while x=1; move to S4 on the edge where x=0; minimum S3 dwell is 1 cycle.
REQ-016 S4 lasts exactly Y2RDELAY cycles, then S0; x ignored.
REQ-017 Dwell counting uses one 8-bit down/up counter cleared on every state entry; counter never wraps (it saturates/stops once the exit condition fires).
REQ-018 x dropping during S1/S2 does not abort the sequence: S3 is still entered, then exits after 1 cycle.
REQ-019 x held at 1 forever keeps S3 indefinitely; x held at 0 forever keeps S0 indefinitely.
REQ-020 Unreachable state encodings recover to S0 on the next edge.
REQ-021 No lamp combination other than those in REQ-011 ever appears; hwy and cntry are never both non-RED.

Reset
REQ-022 clear=0 at a rising edge forces S0 (hwy=2'd2, cntry=2'd0) and zeroes the counter, from any state, including mid-dwell.
REQ-023 While clear=0, state holds S0 and x is ignored; normal operation resumes from the first edge with clear=1.
REQ-024 Before the first reset edge, outputs are undefined; no asynchronous behaviour exists.

Configuration
REQ-025 Macro SIGNAL_CONTROLLER_MIN_GREEN_EN: when defined, S0 ignores x until S0 has been occupied for MIN_HWY_GREEN cycles (S0 -> S1 only on an edge with x=1 and the dwell reached); when undefined, REQ-012 applies unconditionally and MIN_HWY_GREEN is unused.
REQ-026 The reset state and all other transitions are identical with and without the macro.

Verification
REQ-027 Hold clear=0 for 5 edges with x=0, then release -> hwy=2, cntry=0 throughout and stay there while x=0.
REQ-028 After reset, raise x=1 and hold it (macro undefined) -> hwy=1 for 3 cycles, hwy=0/cntry=0 for 2 cycles, then cntry=2 held while x=1.
REQ-029 In S3, drop x to 0 -> cntry=1 for 3 cycles, then hwy=2, cntry=0.
REQ-030 Pulse x=1 for one cycle in S0 -> full sequence S1(3) S2(2) S3(1) S4(3) S0; total 9 cycles back to highway green.
REQ-031 Assert clear=0 during S2 -> next edge hwy=2, cntry=0; no remaining sequence completes.
REQ-032 Macro defined: raise x=1 one cycle after reset release -> hwy stays 2 until the S0 dwell reaches 4 cycles, then hwy=1.
